outfifo_arbiter: RTL and testbench
==================================

// Module: outfifo_arbiter
//
// PURPOSE
//   Return path of the multithreaded packet processor. Reads finished packets
//   from NUM_THREADS per-thread output FIFOs and merges them into one output
//   word stream, one whole packet at a time. Threads are served round-robin.
//   When a packet has been fully drained, the block releases the owning thread
//   so that thread can accept new work from the input-side arbiter.
//
// PARAMETERS
//   NUM_THREADS  8   number of threads / output FIFOs (2..2**THREAD_BITS)
//   THREAD_BITS  3   width of a thread index
//   DATA_WIDTH   64  packet data word width
//   CTRL_WIDTH   8   packet control word width
//
// PORTS
//   clk             in   1                       clock
//   reset           in   1                       synchronous, active-high
//   thread_done     in   NUM_THREADS             level; thread i has a complete packet queued
//   in_data         in   NUM_THREADS*DATA_WIDTH  FWFT FIFO heads, thread i at [i*DW +: DW]
//   in_ctrl         in   NUM_THREADS*CTRL_WIDTH  FWFT ctrl heads, same packing
//   in_lastword     in   NUM_THREADS             head word of FIFO i is end-of-packet
//   in_empty        in   NUM_THREADS             FIFO i empty
//   in_rd_en        out  NUM_THREADS             pop FIFO i (one-hot or zero)
//   thread_release  out  NUM_THREADS             1-cycle pulse: packet of thread i fully sent
//   out_data        out  DATA_WIDTH              registered output word
//   out_ctrl        out  CTRL_WIDTH              registered output ctrl
//   out_wr          out  1                       out_data/out_ctrl valid this cycle
//   out_rdy         in   1                       downstream can accept a word next cycle
//   cur_thread      out  THREAD_BITS             thread currently granted
//   busy            out  1                       FSM is not in IDLE
//
// BEHAVIOUR
//   Reset: FSM=IDLE; rr_ptr=0; cur_thread=0; mask=0. All outputs are 0.
//   FSM states: IDLE, DRAIN, RELEASE.
//   - IDLE:
//       req = thread_done & ~mask.
//       If req != 0: cur_thread <= first set bit of req, searching upward from
//       rr_ptr with wrap; go to DRAIN. No reads are issued in IDLE.
//   - DRAIN:
//       in_rd_en[cur] = out_rdy & ~in_empty[cur]; all other bits are 0 (combinational).
//       Next cycle: out_wr <= that rd_en; out_data/out_ctrl <= head of cur.
//       When rd_en & in_lastword[cur]: go to RELEASE.
//   - RELEASE:
//       thread_release[cur]=1 for exactly this cycle.
//       rr_ptr <= (cur==NUM_THREADS-1) ? 0 : cur+1.
//       mask <= one-hot(cur) for one cycle, so a stale thread_done is not re-granted.
//       Go to IDLE.
//   Latency: grant 1 cycle after req is seen in IDLE. First pop is in the first
//     DRAIN cycle. out_wr follows each pop by exactly 1 cycle. Per-packet
//     overhead is 2 cycles (IDLE, RELEASE).
//   Stalls: in_empty[cur] high mid-packet -> no pop, out_wr=0 next cycle, stay
//     in DRAIN. out_rdy low -> no pop. out_rdy only gates new pops; the word
//     already registered is still presented.
//   Simultaneous requests: round-robin from rr_ptr. A thread that was just
//     served has the lowest priority.
//   Single-word packet (lastword on first pop): DRAIN lasts 1 cycle.
//   thread_done dropping during DRAIN is ignored. The grant holds until lastword.
//   Reset mid-packet: return to IDLE immediately. No release pulse. The
//     partial packet is discarded by the system-wide reset of the FIFOs.
//   busy = (state != IDLE). cur_thread holds its value in IDLE.
//
// STRUCTURE
//   Shared header arya_defines.vh:
//     THREAD_BITS, DATA_WIDTH, CTRL_WIDTH defaults;
//     OA_IDLE/OA_DRAIN/OA_RELEASE state encodings.
//   Sub-module rr_priority_select:
//     inputs req[N], ptr[THREAD_BITS];
//     outputs grant_idx, grant_valid;
//     purely combinational. Reused later by other arbiters.
//   Data and ctrl muxing by cur_thread is done in this module.
//
// TESTING
//   1. thread_done=8'h04; FIFO2 holds 3 words, last marked; out_rdy=1
//      -> cur_thread=2; in_rd_en=8'h04 for 3 cycles; 3 out_wr pulses in order;
//         thread_release=8'h04 one cycle; rr_ptr=3.
//   2. thread_done=8'h81 with rr_ptr=1
//      -> thread 7 is served first, then thread 0.
//      -> release pulses are 8'h80, then 8'h01.
//   3. During a packet, drop out_rdy for 4 cycles
//      -> no pops and no out_wr during the gap; word order is intact;
//         no word is duplicated or dropped.
//   4. Assert in_empty[cur] for 2 cycles mid-packet
//      -> FSM stays in DRAIN; out_wr=0 for 2 cycles; transfer resumes correctly.
//   5. Single-word packet on thread 5, thread_done held 1 cycle past release
//      -> exactly one out_wr; exactly one release; thread 5 is not re-granted.
//   6. Assert reset while draining word 2 of thread 3
//      -> next cycle: busy=0, all outputs 0, no thread_release; rr_ptr=0.

Source files
------------

// File: rtl/outfifo_arbiter_pkg.sv
// Shared defaults and FSM state encodings for the output-FIFO arbiter
// and the round-robin selector it uses.
package outfifo_arbiter_pkg;

    localparam int OA_NUM_THREADS = 8;
    localparam int OA_THREAD_BITS = 3;
    localparam int OA_DATA_WIDTH  = 64;
    localparam int OA_CTRL_WIDTH  = 8;

    typedef logic [1:0] oa_state_t;

    localparam logic [1:0] OA_IDLE    = 2'd0;
    localparam logic [1:0] OA_DRAIN   = 2'd1;
    localparam logic [1:0] OA_RELEASE = 2'd2;

endpackage

// File: rtl/outfifo_arbiter_rr_priority_select.sv
// Combinational round-robin selector: returns the first set request at or
// above ptr, wrapping around, plus a flag saying whether any request is set.
module rr_priority_select
    import outfifo_arbiter_pkg::*;
#(
    parameter int N           = OA_NUM_THREADS,
    parameter int THREAD_BITS = OA_THREAD_BITS
) (
    input  logic [N-1:0]           req,
    input  logic [THREAD_BITS-1:0] ptr,
    output logic [THREAD_BITS-1:0] grant_idx,
    output logic                   grant_valid
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_valid && req[idx[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = THREAD_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/outfifo_arbiter.sv
// Merges whole packets from per-thread FWFT output FIFOs into one word stream,
// serving threads round-robin and pulsing a release when a packet is drained.
module outfifo_arbiter
    import outfifo_arbiter_pkg::*;
#(
    parameter int NUM_THREADS = OA_NUM_THREADS,
    parameter int THREAD_BITS = OA_THREAD_BITS,
    parameter int DATA_WIDTH  = OA_DATA_WIDTH,
    parameter int CTRL_WIDTH  = OA_CTRL_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_THREADS-1:0]            thread_done,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_THREADS*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_THREADS-1:0]            in_lastword,
    input  logic [NUM_THREADS-1:0]            in_empty,
    output logic [NUM_THREADS-1:0]            in_rd_en,
    output logic [NUM_THREADS-1:0]            thread_release,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [CTRL_WIDTH-1:0]             out_ctrl,
    output logic                              out_wr,
    input  logic                              out_rdy,
    output logic [THREAD_BITS-1:0]            cur_thread,
    output logic                              busy
);

    oa_state_t                state_q, state_d;
    logic [THREAD_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [THREAD_BITS-1:0]   cur_q, cur_d;
    logic [NUM_THREADS-1:0]   mask_q, mask_d;
    logic [DATA_WIDTH-1:0]    out_data_q;
    logic [CTRL_WIDTH-1:0]    out_ctrl_q;
    logic                     out_wr_q;

    logic [NUM_THREADS-1:0]   req;
    logic [NUM_THREADS-1:0]   cur_onehot;
    logic [THREAD_BITS-1:0]   grant_idx;
    logic                     grant_valid;
    logic [DATA_WIDTH-1:0]    head_data;
    logic [CTRL_WIDTH-1:0]    head_ctrl;
    logic                     head_last;
    logic                     head_empty;
    logic                     pop;

    assign req = thread_done & ~mask_q;

    rr_priority_select #(
        .N           (NUM_THREADS),
        .THREAD_BITS (THREAD_BITS)
    ) u_select (
        .req         (req),
        .ptr         (rr_ptr_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Select the head of the granted FIFO.
    always_comb begin
        head_data  = '0;
        head_ctrl  = '0;
        head_last  = 1'b0;
        head_empty = 1'b1;
        cur_onehot = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (cur_q == THREAD_BITS'(i)) begin
                head_data     = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                head_ctrl     = in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
                head_last     = in_lastword[i];
                head_empty    = in_empty[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    assign pop            = (state_q == OA_DRAIN) && out_rdy && !head_empty;
    assign in_rd_en       = pop ? cur_onehot : '0;
    assign thread_release = (state_q == OA_RELEASE) ? cur_onehot : '0;

    // The mask only lives for the IDLE cycle right after a release, so a
    // thread_done that has not yet dropped cannot win the next grant.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cur_d    = cur_q;
        mask_d   = '0;
        case (state_q)
            OA_IDLE: begin
                if (grant_valid) begin
                    cur_d   = grant_idx;
                    state_d = OA_DRAIN;
                end
            end
            OA_DRAIN: begin
                if (pop && head_last) begin
                    state_d = OA_RELEASE;
                end
            end
            OA_RELEASE: begin
                rr_ptr_d = (cur_q == THREAD_BITS'(NUM_THREADS - 1)) ? '0 : cur_q + 1'b1;
                mask_d   = cur_onehot;
                state_d  = OA_IDLE;
            end
            default: state_d = OA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= OA_IDLE;
            rr_ptr_q   <= '0;
            cur_q      <= '0;
            mask_q     <= '0;
            out_data_q <= '0;
            out_ctrl_q <= '0;
            out_wr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_q    <= cur_d;
            mask_q   <= mask_d;
            out_wr_q <= pop;
            if (pop) begin
                out_data_q <= head_data;
                out_ctrl_q <= head_ctrl;
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_ctrl   = out_ctrl_q;
    assign out_wr     = out_wr_q;
    assign cur_thread = cur_q;
    assign busy       = (state_q != OA_IDLE);

endmodule

// File: tb/tb_outfifo_arbiter.sv
// Self-checking bench for outfifo_arbiter: emulated per-thread FIFOs, a
// transaction-level round-robin reference model, directed and random traffic.
module tb_outfifo_arbiter;

    localparam int NT = 8;
    localparam int TB = 3;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int WW = DW + CW + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NT-1:0]     thread_done;
    wire  [NT*DW-1:0]  in_data;
    wire  [NT*CW-1:0]  in_ctrl;
    logic [NT-1:0]     in_lastword;
    logic [NT-1:0]     in_empty;
    logic [NT-1:0]     in_rd_en;
    logic [NT-1:0]     thread_release;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ctrl;
    logic              out_wr;
    logic              out_rdy;
    logic [TB-1:0]     cur_thread;
    logic              busy;

    logic [DW-1:0]     headData [NT];
    logic [CW-1:0]     headCtrl [NT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NT; g++) begin : g_pack
        assign in_data[g*DW +: DW] = headData[g];
        assign in_ctrl[g*CW +: CW] = headCtrl[g];
    end

    outfifo_arbiter #(
        .NUM_THREADS (NT),
        .THREAD_BITS (TB),
        .DATA_WIDTH  (DW),
        .CTRL_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .thread_done    (thread_done),
        .in_data        (in_data),
        .in_ctrl        (in_ctrl),
        .in_lastword    (in_lastword),
        .in_empty       (in_empty),
        .in_rd_en       (in_rd_en),
        .thread_release (thread_release),
        .out_data       (out_data),
        .out_ctrl       (out_ctrl),
        .out_wr         (out_wr),
        .out_rdy        (out_rdy),
        .cur_thread     (cur_thread),
        .busy           (busy)
    );

    // Emulated FIFOs: each entry is {lastword, ctrl, data}.
    logic [WW-1:0]  fq [NT][$];
    logic [NT-1:0]  forceEmpty;
    logic [NT-1:0]  holdDone;

    // Reference model: which packet is owned, whether its release is due,
    // the round-robin start point and the thread just served.
    bit             mBusy, mRel, mWr;
    int             mOwner, mPtr, mMask;
    logic [DW+CW-1:0] mWord;
    int             popThread;
    bit             flushFifos;

    int errors = 0;
    int checks = 0;
    int rdCount, wrCount, busyCount, totalWr, pushedWords, droppedWords;
    int relLog[$];

    function automatic logic [TB-1:0] ix(input int v);
        return v[TB-1:0];
    endfunction

    function automatic int rrPick(input logic [NT-1:0] req, input int ptr);
        for (int k = 0; k < NT; k++) begin
            int j;
            j = (ptr + k) % NT;
            if (req[ix(j)]) return j;
        end
        return -1;
    endfunction

    function automatic bit hasLast(input int t);
        logic [WW-1:0] w;
        for (int k = 0; k < fq[ix(t)].size(); k++) begin
            w = fq[ix(t)][k];
            if (w[WW-1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit allEmpty();
        for (int i = 0; i < NT; i++) begin
            if (fq[ix(i)].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int relAt(input int k);
        if (k < relLog.size()) return relLog[k];
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int t, input int len);
        logic [WW-1:0] w;
        for (int k = 0; k < len; k++) begin
            w = {(k == len - 1), CW'($urandom), $urandom, $urandom};
            fq[ix(t)].push_back(w);
            pushedWords++;
        end
    endtask

    task automatic driveHeads();
        logic [WW-1:0] w;
        for (int i = 0; i < NT; i++) begin
            if (fq[ix(i)].size() > 0) begin
                w = fq[ix(i)][0];
                headData[ix(i)]    = w[DW-1:0];
                headCtrl[ix(i)]    = w[DW+CW-1:DW];
                in_lastword[ix(i)] = w[WW-1];
                in_empty[ix(i)]    = forceEmpty[ix(i)];
            end else begin
                headData[ix(i)]    = '0;
                headCtrl[ix(i)]    = '0;
                in_lastword[ix(i)] = 1'b0;
                in_empty[ix(i)]    = 1'b1;
            end
            thread_done[ix(i)] = hasLast(i) | holdDone[ix(i)];
        end
    endtask

    task automatic checkCycle();
        logic [NT-1:0]  expRd, expRel, req;
        logic [WW-1:0]  head;
        bit             expPop;
        int             p;
        head   = '0;
        expPop = mBusy && out_rdy && (fq[ix(mOwner)].size() > 0) && !forceEmpty[ix(mOwner)];
        expRd  = '0;
        expRel = '0;
        if (expPop) expRd[ix(mOwner)] = 1'b1;
        if (mRel)   expRel[ix(mOwner)] = 1'b1;
        checkOutput("rd_en", 80'(in_rd_en), 80'(expRd));
        checkOutput("release", 80'(thread_release), 80'(expRel));
        checkOutput("busy", 80'(busy), 80'(mBusy | mRel));
        checkOutput("cur_thread", 80'(cur_thread), 80'(mOwner));
        checkOutput("out_wr", 80'(out_wr), 80'(mWr));
        if (mWr) checkOutput("out_word", 80'({out_ctrl, out_data}), 80'(mWord));
        if (in_rd_en != 0) rdCount++;
        if (out_wr) begin
            wrCount++;
            totalWr++;
        end
        if (busy) busyCount++;
        for (int i = 0; i < NT; i++) begin
            if (thread_release[ix(i)]) relLog.push_back(i);
        end

        popThread  = -1;
        flushFifos = 1'b0;
        if (reset) begin
            mBusy = 0; mRel = 0; mWr = 0; mOwner = 0; mPtr = 0; mMask = -1;
            flushFifos = 1'b1;
        end else begin
            mWr = expPop;
            if (expPop) begin
                head      = fq[ix(mOwner)][0];
                mWord     = head[DW+CW-1:0];
                popThread = mOwner;
            end
            if (mRel) begin
                mPtr  = (mOwner + 1) % NT;
                mMask = mOwner;
                mRel  = 0;
            end else begin
                if (mBusy) begin
                    if (expPop && head[WW-1]) begin
                        mBusy = 0;
                        mRel  = 1;
                    end
                end else begin
                    req = thread_done;
                    if (mMask >= 0) req[ix(mMask)] = 1'b0;
                    p = rrPick(req, mPtr);
                    if (p >= 0) begin
                        mOwner = p;
                        mBusy  = 1;
                    end
                end
                mMask = -1;
            end
        end
    endtask

    task automatic cycle();
        driveHeads();
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        #1;
        if (flushFifos) begin
            for (int i = 0; i < NT; i++) begin
                droppedWords += fq[ix(i)].size();
                fq[ix(i)].delete();
            end
        end else if (popThread >= 0) begin
            void'(fq[ix(popThread)].pop_front());
        end
        driveHeads();
    endtask

    task automatic runUntilIdle(input string tag, input int bound);
        int n;
        n = 0;
        while (!(allEmpty() && !mBusy && !mRel) && n < bound) begin
            cycle();
            n++;
        end
        checkOutput(tag, 80'(n >= bound), 80'(0));
    endtask

    task automatic clearStats();
        rdCount = 0; wrCount = 0; busyCount = 0;
        relLog.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0, w0, b0, n;
        reset = 1'b1; out_rdy = 1'b1; forceEmpty = '0; holdDone = '0;
        mBusy = 0; mRel = 0; mWr = 0; mOwner = 0; mPtr = 0; mMask = -1; mWord = '0;
        totalWr = 0; pushedWords = 0; droppedWords = 0;
        clearStats();
        driveHeads();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_out_data", 80'(out_data), 80'(0));
        checkOutput("reset_out_ctrl", 80'(out_ctrl), 80'(0));
        checkOutput("reset_out_wr", 80'(out_wr), 80'(0));
        checkOutput("reset_busy", 80'(busy), 80'(0));
        checkOutput("reset_cur", 80'(cur_thread), 80'(0));
        checkOutput("reset_rd_en", 80'(in_rd_en), 80'(0));
        checkOutput("reset_release", 80'(thread_release), 80'(0));

        $display("[TB] three-word packet on thread 2");
        clearStats();
        applyStimulus(2, 3);
        cycle();
        checkOutput("t1_grant", 80'(cur_thread), 80'(2));
        repeat (7) cycle();
        checkOutput("t1_pops", 80'(rdCount), 80'(3));
        checkOutput("t1_writes", 80'(wrCount), 80'(3));
        checkOutput("t1_rel_count", 80'(relLog.size()), 80'(1));
        checkOutput("t1_rel_thread", 80'(relAt(0)), 80'(2));

        $display("[TB] pointer after thread 2: threads 0 and 3 together");
        clearStats();
        applyStimulus(0, 2);
        applyStimulus(3, 2);
        runUntilIdle("t1b_timeout", 40);
        checkOutput("t1b_first", 80'(relAt(0)), 80'(3));
        checkOutput("t1b_second", 80'(relAt(1)), 80'(0));

        $display("[TB] threads 7 and 0 with pointer at 1");
        clearStats();
        applyStimulus(7, 2);
        applyStimulus(0, 2);
        runUntilIdle("t2_timeout", 40);
        checkOutput("t2_first", 80'(relAt(0)), 80'(7));
        checkOutput("t2_second", 80'(relAt(1)), 80'(0));

        $display("[TB] out_rdy gap mid-packet");
        clearStats();
        applyStimulus(4, 6);
        repeat (3) cycle();
        out_rdy = 1'b0;
        r0 = rdCount;
        cycle();
        w0 = wrCount;
        repeat (3) cycle();
        checkOutput("t3_gap_pops", 80'(rdCount - r0), 80'(0));
        checkOutput("t3_gap_writes", 80'(wrCount - w0), 80'(0));
        out_rdy = 1'b1;
        runUntilIdle("t3_timeout", 40);
        checkOutput("t3_words", 80'(wrCount), 80'(6));

        $display("[TB] empty FIFO mid-packet");
        clearStats();
        applyStimulus(6, 5);
        repeat (2) cycle();
        forceEmpty[6] = 1'b1;
        r0 = rdCount;
        b0 = busyCount;
        cycle();
        w0 = wrCount;
        cycle();
        checkOutput("t4_stall_pops", 80'(rdCount - r0), 80'(0));
        checkOutput("t4_stall_busy", 80'(busyCount - b0), 80'(2));
        forceEmpty[6] = 1'b0;
        cycle();
        checkOutput("t4_stall_writes", 80'(wrCount - w0), 80'(0));
        runUntilIdle("t4_timeout", 40);
        checkOutput("t4_words", 80'(wrCount), 80'(5));

        $display("[TB] single-word packet on thread 5 with lingering done");
        clearStats();
        holdDone[5] = 1'b1;
        applyStimulus(5, 1);
        n = 0;
        while (relLog.size() == 0 && n < 10) begin
            cycle();
            n++;
        end
        checkOutput("t5_timeout", 80'(n >= 10), 80'(0));
        cycle();
        holdDone[5] = 1'b0;
        repeat (3) cycle();
        checkOutput("t5_writes", 80'(wrCount), 80'(1));
        checkOutput("t5_releases", 80'(relLog.size()), 80'(1));
        checkOutput("t5_busy_cycles", 80'(busyCount), 80'(2));

        $display("[TB] reset while draining thread 3");
        clearStats();
        applyStimulus(3, 4);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checkOutput("t6_busy", 80'(busy), 80'(0));
        checkOutput("t6_out_wr", 80'(out_wr), 80'(0));
        checkOutput("t6_out_data", 80'(out_data), 80'(0));
        checkOutput("t6_rd_en", 80'(in_rd_en), 80'(0));
        checkOutput("t6_release", 80'(thread_release), 80'(0));
        checkOutput("t6_cur", 80'(cur_thread), 80'(0));
        applyStimulus(7, 2);
        applyStimulus(1, 2);
        runUntilIdle("t6_timeout", 40);
        checkOutput("t6_no_release", 80'(relLog.size()), 80'(2));
        checkOutput("t6_first", 80'(relAt(0)), 80'(1));
        checkOutput("t6_second", 80'(relAt(1)), 80'(7));

        $display("[TB] random traffic");
        for (int c = 0; c < 800; c++) begin
            int t;
            if ($urandom_range(0, 5) == 0) begin
                t = $urandom_range(0, NT - 1);
                if (fq[ix(t)].size() < 10) applyStimulus(t, $urandom_range(1, 4));
            end
            out_rdy    = ($urandom_range(0, 9) != 0);
            forceEmpty = NT'($urandom) & NT'($urandom) & NT'($urandom) & NT'($urandom);
            cycle();
        end
        forceEmpty = '0;
        out_rdy    = 1'b1;
        runUntilIdle("rand_timeout", 600);
        checkOutput("rand_all_words", 80'(totalWr), 80'(pushedWords - droppedWords));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
